// File: rtl/soc_mmio_pkg.sv
// rtl/soc_mmio_pkg.sv - shared register map and defaults for the SoC MMIO peripherals
package soc_mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_1000;

  // Byte offsets inside the 32-byte register window
  localparam logic [4:0] OFF_LED_OUT   = 5'h00;
  localparam logic [4:0] OFF_LED_SET   = 5'h04;
  localparam logic [4:0] OFF_LED_CLR   = 5'h08;
  localparam logic [4:0] OFF_LED_TGL   = 5'h0C;
  localparam logic [4:0] OFF_BLINK_CFG = 5'h10;
  localparam logic [4:0] OFF_TIMER     = 5'h14;
  localparam logic [4:0] OFF_TIMER_CMP = 5'h18;
  localparam logic [4:0] OFF_STATUS    = 5'h1C;

  localparam int STATUS_MATCH_BIT  = 0;
  localparam int STATUS_IRQ_EN_BIT = 1;

  localparam int BLINK_MASK_W     = 5;
  localparam int BLINK_RELOAD_LSB = 8;

  function automatic logic [2:0] reg_idx(input logic [4:0] off);
    return off[4:2];
  endfunction

endpackage

// File: rtl/blink_prescaler.sv
// rtl/blink_prescaler.sv - reloadable down-counter that toggles the blink phase on underflow
module blink_prescaler #(
  parameter int PRESC_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PRESC_W-1:0] reload,
  output logic               phase
);

  logic [PRESC_W-1:0] presc;

  // The reload value is only sampled at zero, so config writes never restart a half-period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      phase <= 1'b0;
    end else if (presc == '0) begin
      presc <= reload;
      phase <= ~phase;
    end else begin
      presc <= presc - 1'b1;
    end
  end

endmodule

// File: rtl/led_timer_mmio.sv
// rtl/led_timer_mmio.sv - LED register with set/clear/toggle aliases, blink generator and compare timer
module led_timer_mmio
  import soc_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          LED_W     = 5,
  parameter int          PRESC_W   = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      data_addr,
  input  logic             data_wr_en,
  input  logic [31:0]      data_wr,
  output logic [31:0]      data_rd,
  output logic             sel,
  output logic [LED_W-1:0] led,
  output logic             irq
);

  logic [2:0]              idx;
  logic                    wr_hit;
  logic [LED_W-1:0]        wdata_led;
  logic [LED_W-1:0]        led_out;
  logic [BLINK_MASK_W-1:0] blink_mask;
  logic [LED_W-1:0]        mask_led;
  logic [PRESC_W-1:0]      reload;
  logic                    phase;
  logic [31:0]             timer;
  logic [31:0]             timer_cmp;
  logic                    match;
  logic                    irq_en;
  logic                    unused_addr_bits;

  assign sel              = (data_addr[31:5] == BASE_ADDR[31:5]);
  assign idx              = data_addr[4:2];
  assign wr_hit           = data_wr_en & sel;
  assign wdata_led        = data_wr[LED_W-1:0];
  assign unused_addr_bits = ^data_addr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out <= '0;
    end else if (wr_hit) begin
      case (idx)
        reg_idx(OFF_LED_OUT): led_out <= wdata_led;
        reg_idx(OFF_LED_SET): led_out <= led_out | wdata_led;
        reg_idx(OFF_LED_CLR): led_out <= led_out & ~wdata_led;
        reg_idx(OFF_LED_TGL): led_out <= led_out ^ wdata_led;
        default:              led_out <= led_out;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_mask <= '0;
      reload     <= '0;
    end else if (wr_hit && idx == reg_idx(OFF_BLINK_CFG)) begin
      blink_mask <= data_wr[BLINK_MASK_W-1:0];
      reload     <= data_wr[BLINK_RELOAD_LSB +: PRESC_W];
    end
  end

  blink_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_blink_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .reload(reload),
    .phase (phase)
  );

  // Only the low BLINK_MASK_W LEDs can blink; wider LED banks get zero mask bits
  for (genvar i = 0; i < LED_W; i++) begin : g_mask
    if (i < BLINK_MASK_W) begin : g_on
      assign mask_led[i] = blink_mask[i];
    end else begin : g_off
      assign mask_led[i] = 1'b0;
    end
  end

  assign led = led_out ^ (mask_led & {LED_W{phase}});

  // A CPU load of the count wins over the free-running increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (wr_hit && idx == reg_idx(OFF_TIMER)) begin
      timer <= data_wr;
    end else begin
      timer <= timer + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_cmp <= '0;
    end else if (wr_hit && idx == reg_idx(OFF_TIMER_CMP)) begin
      timer_cmp <= data_wr;
    end
  end

  // Hardware set takes priority over a same-cycle write-1-to-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match  <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      if (timer == timer_cmp) begin
        match <= 1'b1;
      end else if (wr_hit && idx == reg_idx(OFF_STATUS) && data_wr[STATUS_MATCH_BIT]) begin
        match <= 1'b0;
      end
      if (wr_hit && idx == reg_idx(OFF_STATUS)) begin
        irq_en <= data_wr[STATUS_IRQ_EN_BIT];
      end
    end
  end

  assign irq = match & irq_en;

  always_comb begin
    data_rd = '0;
    if (sel) begin
      case (idx)
        reg_idx(OFF_LED_OUT):   data_rd = 32'(led_out);
        reg_idx(OFF_BLINK_CFG): data_rd = {24'(reload), 3'b000, blink_mask};
        reg_idx(OFF_TIMER):     data_rd = timer;
        reg_idx(OFF_TIMER_CMP): data_rd = timer_cmp;
        reg_idx(OFF_STATUS): begin
          data_rd[STATUS_MATCH_BIT]  = match;
          data_rd[STATUS_IRQ_EN_BIT] = irq_en;
        end
        default:                data_rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_timer_mmio.sv
// tb/tb_led_timer_mmio.sv - directed vector bench for led_timer_mmio
module tb_led_timer_mmio;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_addr;
  logic        data_wr_en;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        sel;
  logic [4:0]  led;
  logic        irq;

  int passed;
  int total;

  led_timer_mmio #(
    .BASE_ADDR(BASE),
    .LED_W    (5),
    .PRESC_W  (24)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_addr (data_addr),
    .data_wr_en(data_wr_en),
    .data_wr   (data_wr),
    .data_rd   (data_rd),
    .sel       (sel),
    .led       (led),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  off;
    logic [31:0] wdata;
    logic [4:0]  exp_led;
  } vec_t;

  vec_t vt [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // All tasks start and end on a negedge; each wr/idle spans exactly one rising edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    data_addr  = a;
    data_wr    = d;
    data_wr_en = 1'b1;
    @(negedge clk);
    data_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    data_addr = a;
    #1;
    d = data_rd;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] r;
  logic [4:0]  s [17];
  logic [4:0]  exp_blink;

  initial begin
    passed     = 0;
    total      = 0;
    rst_n      = 1'b0;
    data_addr  = BASE;
    data_wr    = '0;
    data_wr_en = 1'b0;

    vt[0] = '{off: 5'h00, wdata: 32'h05, exp_led: 5'h05};
    vt[1] = '{off: 5'h04, wdata: 32'h0A, exp_led: 5'h0F};
    vt[2] = '{off: 5'h08, wdata: 32'h01, exp_led: 5'h0E};
    vt[3] = '{off: 5'h0C, wdata: 32'h1F, exp_led: 5'h11};

    // Reset and first count
    idle(2);
    check("reset_led", 32'(led), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    rd(BASE + 32'h14, r);
    check("reset_timer", r, 32'h0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    rd(BASE + 32'h14, r);
    check("timer_after_release", r, 32'h1);

    // Asynchronous reset mid-count with live LED and IRQ state
    wr(BASE + 32'h00, 32'h1F);
    wr(BASE + 32'h1C, 32'h2);
    check("pre_reset_led", 32'(led), 32'h1F);
    check("pre_reset_irq", 32'(irq), 32'h1);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_led", 32'(led), 32'h0);
    check("async_reset_irq", 32'(irq), 32'h0);
    rd(BASE + 32'h14, r);
    check("async_reset_timer", r, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    rd(BASE + 32'h14, r);
    check("timer_after_rerelease", r, 32'h1);

    // LED alias table
    for (int i = 0; i < 4; i++) begin
      wr(BASE + 32'(vt[i].off), vt[i].wdata);
      check($sformatf("alias_led_%0d", i), 32'(led), 32'(vt[i].exp_led));
      rd(BASE + 32'(vt[i].off), r);
      check($sformatf("alias_rd_%0d", i), r, (vt[i].off == 5'h00) ? 32'(vt[i].exp_led) : 32'h0);
    end

    // Blink: mask 0x10, reload 3 -> 4-cycle half period; bits [7:5] read back 0
    wr(BASE + 32'h00, 32'h01);
    wr(BASE + 32'h10, 32'h0000_03F0);
    s[0] = led;
    for (int j = 1; j < 17; j++) begin
      @(negedge clk);
      s[j] = led;
    end
    check("blink_first_toggle", 32'(s[0] ^ s[1]), 32'h10);
    check("blink_base", 32'(s[1] & 5'h0F), 32'h01);
    for (int j = 1; j < 17; j++) begin
      exp_blink = (((j - 1) / 4) % 2 == 0) ? s[1] : (s[1] ^ 5'h10);
      check($sformatf("blink_%0d", j), 32'(s[j]), 32'(exp_blink));
    end
    rd(BASE + 32'h10, r);
    check("blink_cfg_rd", r, 32'h0000_0310);
    wr(BASE + 32'h10, 32'h0);
    check("blink_off_led", 32'(led), 32'h01);

    // Timer wrap, match and IRQ
    wr(BASE + 32'h1C, 32'h1);
    wr(BASE + 32'h14, 32'hFFFF_FFFE);
    wr(BASE + 32'h18, 32'h0000_0001);
    wr(BASE + 32'h1C, 32'h2);
    rd(BASE + 32'h14, r);
    check("timer_wrap", r, 32'h0);
    idle(1);
    rd(BASE + 32'h14, r);
    check("timer_at_cmp", r, 32'h1);
    check("irq_before_match", 32'(irq), 32'h0);
    idle(1);
    check("irq_after_match", 32'(irq), 32'h1);
    rd(BASE + 32'h1C, r);
    check("status_match", r, 32'h3);
    wr(BASE + 32'h1C, 32'h3);
    check("irq_w1c", 32'(irq), 32'h0);

    // W1C on the exact set cycle loses to the hardware set
    wr(BASE + 32'h18, 32'h200);
    wr(BASE + 32'h14, 32'h1FF);
    idle(1);
    check("collide_pre_irq", 32'(irq), 32'h0);
    wr(BASE + 32'h1C, 32'h3);
    check("collide_w1c_irq", 32'(irq), 32'h1);
    rd(BASE + 32'h1C, r);
    check("collide_w1c_status", r, 32'h3);

    // Timer load beats the increment
    wr(BASE + 32'h14, 32'h100);
    rd(BASE + 32'h14, r);
    check("timer_load", r, 32'h100);

    // Decode boundaries
    wr(BASE + 32'h20, 32'h1F);
    check("miss_hi_led", 32'(led), 32'h01);
    rd(BASE + 32'h20, r);
    check("miss_hi_sel", 32'(sel), 32'h0);
    check("miss_hi_rd", r, 32'h0);
    wr(BASE - 32'h4, 32'h1);
    check("miss_lo_irq", 32'(irq), 32'h1);
    rd(BASE - 32'h4, r);
    check("miss_lo_sel", 32'(sel), 32'h0);
    rd(BASE + 32'h03, r);
    check("byte_addr_rd", r, 32'h01);
    wr(BASE + 32'h07, 32'h02);
    check("byte_addr_set", 32'(led), 32'h03);
    data_addr  = BASE;
    data_wr    = 32'h1F;
    data_wr_en = 1'b0;
    idle(1);
    check("no_wr_en", 32'(led), 32'h03);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/led_timer_mmio.md
# led_timer_mmio

Memory-mapped peripheral on the CPU data bus of the single-cycle RISC-V SoC.
- Owns the LED output register with set, clear and toggle aliases.
- Adds a hardware blink generator and a 32-bit free-running timer with compare flag and interrupt.
- Sits directly downstream of the CPU data port and replaces the bare `led_wr` latch in `soc`.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_1000: 32-byte aligned base of the register window.
- `LED_W`, default 5: number of LED outputs.
- `PRESC_W`, default 24: blink prescaler width.

Ports (name, direction, width, meaning):
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_addr` in 32: CPU byte address.
- `data_wr_en` in 1: write strobe, one cycle per store.
- `data_wr` in 32: CPU write data.
- `data_rd` out 32: read data, combinational.
- `sel` out 1: address hits the window; the CPU read mux uses it.
- `led` out LED_W: LED pins.
- `irq` out 1: timer interrupt, level.

## Operation
- Hit condition: `data_addr[31:5] == BASE_ADDR[31:5]`. Register index is `data_addr[4:2]`; `data_addr[1:0]` is ignored. Writes are full-word only.
- Registers (offset, name, access):
  - 0x00 `LED_OUT`, rw, bits [LED_W-1:0].
  - 0x04 `LED_SET`, w: `LED_OUT |= data`; reads 0.
  - 0x08 `LED_CLR`, w: `LED_OUT &= ~data`; reads 0.
  - 0x0C `LED_TGL`, w: `LED_OUT ^= data`; reads 0.
  - 0x10 `BLINK_CFG`, rw:
    - [4:0] blink mask.
    - [31:8] prescaler reload, PRESC_W bits used; upper bits are written and ignored, and read 0.
  - 0x14 `TIMER`, rw: a write loads the count.
  - 0x18 `TIMER_CMP`, rw.
  - 0x1C `STATUS`:
    - bit0 `MATCH` is sticky; writing 1 clears it.
    - bit1 `IRQ_EN` is rw.
- Unused register bits read 0.
- Blink generator:
  - `presc` down-counter. When `presc == 0`, it reloads from `BLINK_CFG` reload and `phase` toggles; otherwise it decrements.
  - A reload value of 0 toggles `phase` every cycle.
  - `led = LED_OUT ^ (blink_mask & {LED_W{phase}})`.
- Timer:
  - Increments every cycle and wraps 0xFFFF_FFFF -> 0.
  - `MATCH` sets on the cycle after `TIMER == TIMER_CMP`.
  - `irq = MATCH & IRQ_EN`.
- Simultaneous events:
  - A CPU write to `TIMER` beats the increment: the next value is the written value, not value+1.
  - A hardware `MATCH` set beats a W1C on the same cycle: the flag stays 1.
  - A write to `BLINK_CFG` does not reset `presc` or `phase`. The new reload takes effect at the next reload.
- Writes with no hit, or with `data_wr_en` = 0, change nothing. Reads have no side effects.

## Timing
- Reset (`rst_n` = 0, asynchronous): all registers go to 0, including `presc`, `phase`, `TIMER`, `TIMER_CMP`, `MATCH` and `IRQ_EN`.
  - Outputs during reset: `led` = 0, `irq` = 0.
  - `sel` and `data_rd` remain combinational on the address.
  - A reset mid-blink or mid-count discards the state.
- Writes are captured on the rising edge where `data_wr_en` = 1 and `sel` = 1. They are visible on `led` and `data_rd` from the next cycle.
- Reads have zero latency: `data_rd` reflects the current register state in the same cycle, as required by the single-cycle CPU.
- Timer compare has one cycle of latency, from `TIMER == TIMER_CMP` to `MATCH`/`irq` = 1.
- Blink period is `2*(reload+1)` cycles per full on/off cycle.

## Structure
- Package `soc_mmio_pkg` holds:
  - register offset localparams (`OFF_LED_OUT` … `OFF_STATUS`);
  - `STATUS` bit indices;
  - the default `BASE_ADDR`.
- Sub-module `blink_prescaler`:
  - Inputs: `clk`, `rst_n`, `reload[PRESC_W-1:0]`.
  - Output: `phase`.
  - Holds the down-counter and phase flop.
- Everything else is in the top: decode, register file, timer, read mux.

## Test plan
- Reset: hold `rst_n` = 0 with `TIMER` counting → `led` = 0, `irq` = 0, and a read of 0x14 returns 0. Release → `TIMER` reads 1 one cycle later.
- LED aliases: write 0x00 = 0x05, then 0x04 = 0x0A, then 0x08 = 0x01, then 0x0C = 0x1F → `led` reads 0x05, 0x0F, 0x0E, then 0x11, each one cycle after its write. Reads of 0x04, 0x08 and 0x0C return 0.
- Blink: `LED_OUT` = 0x01, `BLINK_CFG` = 0x0000_0310 (mask 0x10, reload 3) → `led` alternates 0x01 and 0x11 every 4 cycles.
- Timer match and IRQ: write `TIMER` = 0xFFFF_FFFE, `TIMER_CMP` = 0x0000_0001, `STATUS` = 0x2 → count wraps through 0. `MATCH` = 1 and `irq` = 1 on the cycle after `TIMER` = 1. A W1C write of 0x3 then clears `irq`.
- Collisions:
  - Write `TIMER` = 0x100 on a cycle where an increment is due → the next read is 0x100.
  - W1C on the exact set cycle → `MATCH` stays 1.
- Decode: a write to `BASE_ADDR` + 0x20 and to `BASE_ADDR` − 4 → no register changes and `sel` = 0. `data_addr[1:0]` = 2'b11 still hits the correct word.
